// File: rtl/eeg_pkg.sv
// Shared types and constants for the EEG UART framer: frame layout, FSM states and
// the sample-pair record that travels through the FIFO.
package eeg_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } framer_state_t;

    typedef struct packed {
        logic [15:0] filtered;
        logic [15:0] weight;
    } sample_pair_t;

    // Byte idx of the frame for pair p; the last byte is the XOR of the four payload bytes.
    function automatic logic [7:0] frame_byte(input sample_pair_t p, input logic [2:0] idx);
        logic [7:0] result;
        case (idx)
            3'd0:    result = SYNC_BYTE;
            3'd1:    result = p.filtered[15:8];
            3'd2:    result = p.filtered[7:0];
            3'd3:    result = p.weight[15:8];
            3'd4:    result = p.weight[7:0];
            default: result = p.filtered[15:8] ^ p.filtered[7:0] ^ p.weight[15:8] ^ p.weight[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/eeg_uart_framer_if.sv
// Valid/ready sample-pair stream from the EEG adaptive filter into the UART framer.
interface eeg_uart_framer_if #(
    parameter int DATA_W = 16
);

    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] filtered_signal;
    logic [DATA_W-1:0] weight;

    modport master (
        output sample_valid,
        output filtered_signal,
        output weight,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  filtered_signal,
        input  weight,
        output sample_ready
    );

endinterface

// File: rtl/eeg_sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push while full is ignored even if a pop
// happens in the same cycle, since full is decided from the registered count.
module eeg_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; clearing the pointers and count is what discards entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/eeg_uart_framer.sv
// Buffers {filtered, weight} pairs and sends each as a 6-byte UART 8N1 frame
// (A5, F hi, F lo, W hi, W lo, XOR checksum) to the host PC.
module eeg_uart_framer
    import eeg_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    eeg_uart_framer_if.slave        s_if,
    output logic                    tx,
    output logic                    busy,
    output logic                    overflow,
    output logic [15:0]             frame_count
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    framer_state_t       state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          shift_q, shift_d;
    sample_pair_t        frame_q, frame_d;
    logic                tx_q, tx_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_wr_data;
    logic [2*DATA_W-1:0] fifo_rd_data;
    logic                baud_tick;

    assign s_if.sample_ready = !fifo_full;
    assign fifo_push         = s_if.sample_valid && !fifo_full;
    assign fifo_wr_data      = {s_if.filtered_signal, s_if.weight};
    assign baud_tick         = (baud_q == BAUD_LAST);

    eeg_sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        byte_idx_d    = byte_idx_q;
        shift_d       = shift_q;
        frame_d       = frame_q;
        frame_count_d = frame_count_q;
        fifo_pop      = 1'b0;
        overflow_d    = overflow_q | (s_if.sample_valid && fifo_full);

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    frame_d    = sample_pair_t'(fifo_rd_data);
                    byte_idx_d = 3'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                shift_d = frame_byte(frame_q, byte_idx_q);
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = LOAD;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered, so it follows the state one cycle later.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            frame_q       <= '0;
            tx_q          <= 1'b1;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            byte_idx_q    <= byte_idx_d;
            shift_q       <= shift_d;
            frame_q       <= frame_d;
            tx_q          <= tx_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_eeg_uart_framer.sv
// Directed bench for eeg_uart_framer: a line receiver decodes tx into bytes and start
// times, and the main sequence compares them against hand-computed frames.
module tb_eeg_uart_framer;
    import eeg_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = CLK_DIV / 2;
    localparam int BYTE_CYC   = 10 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_count;

    eeg_uart_framer_if #(.DATA_W(16)) s_if ();

    eeg_uart_framer #(
        .CLK_DIV    (CLK_DIV),
        .DATA_W     (16),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_if        (s_if),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] byte_q[$];
    int         start_q[$];
    int         rx_errs = 0;
    logic       rx_active = 1'b0;

    task automatic check_output(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line receiver: samples mid-bit on the falling clock edge.
    initial begin
        int         cyc;
        int         rx_start;
        int         off;
        logic       prev_tx;
        logic [7:0] rx_shift;
        cyc      = 0;
        rx_start = 0;
        prev_tx  = 1'b1;
        rx_shift = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (prev_tx === 1'b1 && tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_start  = cyc;
                end
            end else begin
                off = cyc - rx_start;
                if (off == HALF && tx !== 1'b0) rx_errs++;
                if (off >= CLK_DIV + HALF && off <= 8 * CLK_DIV + HALF && (off - HALF) % CLK_DIV == 0)
                    rx_shift = {tx, rx_shift[7:1]};
                if (off == 9 * CLK_DIV + HALF) begin
                    if (tx !== 1'b1) rx_errs++;
                    byte_q.push_back(rx_shift);
                    start_q.push_back(rx_start);
                    rx_active = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    task automatic push_pair(input logic [15:0] f, input logic [15:0] w);
        @(negedge clk);
        s_if.sample_valid    = 1'b1;
        s_if.filtered_signal = f;
        s_if.weight          = w;
        @(posedge clk);
        #1;
        s_if.sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output(tag, 48'(byte_q.size() >= n), 48'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output(tag, 48'(busy), 48'd0);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] f, input logic [15:0] w);
        logic [7:0] chk;
        chk = f[15:8] ^ f[7:0] ^ w[15:8] ^ w[7:0];
        if (byte_q.size() >= base + 6) begin
            check_output({tag, "_bytes"},
                         {byte_q[base], byte_q[base+1], byte_q[base+2],
                          byte_q[base+3], byte_q[base+4], byte_q[base+5]},
                         {8'hA5, f, w, chk});
            for (int k = 1; k < 6; k++)
                check_output({tag, "_spacing"}, 48'(start_q[base+k] - start_q[base+k-1]), 48'(BYTE_CYC));
        end else begin
            check_output({tag, "_missing"}, 48'(byte_q.size()), 48'(base + 6));
        end
    endtask

    task automatic clear_rx();
        byte_q.delete();
        start_q.delete();
    endtask

    initial begin
        int accepted;
        int lows;
        logic ready_at_10;

        reset                = 1'b1;
        s_if.sample_valid    = 1'b0;
        s_if.filtered_signal = '0;
        s_if.weight          = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_tx", 48'(tx), 48'd1);
        check_output("rst_ready", 48'(s_if.sample_ready), 48'd1);
        check_output("rst_busy", 48'(busy), 48'd0);
        check_output("rst_overflow", 48'(overflow), 48'd0);
        check_output("rst_frame_count", 48'(frame_count), 48'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] single pair 1234/00FF");
        clear_rx();
        push_pair(16'h1234, 16'h00FF);
        @(posedge clk); #1;
        check_output("t1_busy", 48'(busy), 48'd1);
        @(posedge clk); #1;
        check_output("t1_tx_n2", 48'(tx), 48'd1);
        @(posedge clk); #1;
        check_output("t1_tx_n3", 48'(tx), 48'd0);
        wait_bytes("t1_timeout", 6, 400);
        check_frame("t1", 0, 16'h1234, 16'h00FF);
        wait_idle("t1_idle", 20);
        check_output("t1_frame_count", 48'(frame_count), 48'd1);

        $display("[TB] zero pair");
        clear_rx();
        push_pair(16'h0000, 16'h0000);
        wait_bytes("t2_timeout", 6, 400);
        check_frame("t2", 0, 16'h0000, 16'h0000);
        wait_idle("t2_idle", 20);
        check_output("t2_frame_count", 48'(frame_count), 48'd2);

        $display("[TB] back-to-back pairs, second pushed during the idle pop");
        clear_rx();
        push_pair(16'hABCD, 16'h5A5A);
        @(negedge clk);
        s_if.sample_valid    = 1'b1;
        s_if.filtered_signal = 16'h0102;
        s_if.weight          = 16'h0304;
        @(posedge clk); #1;
        s_if.sample_valid = 1'b0;
        check_output("t3_fifo_count", 48'(dut.u_fifo.count_q), 48'd1);
        check_output("t3_busy", 48'(busy), 48'd1);
        wait_bytes("t3_timeout", 12, 800);
        check_frame("t3_f1", 0, 16'hABCD, 16'h5A5A);
        check_frame("t3_f2", 6, 16'h0102, 16'h0304);
        if (start_q.size() >= 7)
            check_output("t3_frame_gap", 48'(start_q[6] - start_q[5]), 48'(BYTE_CYC + 1));
        wait_idle("t3_idle", 20);
        check_output("t3_frame_count", 48'(frame_count), 48'd4);
        check_output("t3_overflow", 48'(overflow), 48'd0);

        $display("[TB] ten consecutive valids from reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_rx();
        accepted    = 0;
        ready_at_10 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            s_if.sample_valid    = 1'b1;
            s_if.filtered_signal = 16'(i);
            s_if.weight          = 16'hF000 | 16'(i);
            if (s_if.sample_ready === 1'b1) accepted++;
            if (i == 10) ready_at_10 = s_if.sample_ready;
        end
        @(negedge clk);
        s_if.sample_valid = 1'b0;
        check_output("t4_accepted", 48'(accepted), 48'd9);
        check_output("t4_ready_at_10", 48'(ready_at_10), 48'd0);
        check_output("t4_overflow", 48'(overflow), 48'd1);
        wait_bytes("t4_timeout", 54, 9 * 300);
        for (int i = 1; i <= 9; i++)
            check_frame("t4", (i - 1) * 6, 16'(i), 16'hF000 | 16'(i));
        wait_idle("t4_idle", 20);
        check_output("t4_frame_count", 48'(frame_count), 48'd9);

        $display("[TB] reset during byte 3 with three pairs queued");
        clear_rx();
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        push_pair(16'h5555, 16'h6666);
        push_pair(16'h7777, 16'h8888);
        wait_bytes("t5_timeout", 2, 200);
        lows = 0;
        while (!rx_active && lows < 20) begin
            @(negedge clk);
            lows++;
        end
        check_output("t5_byte3_started", 48'(rx_active), 48'd1);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("t5_tx", 48'(tx), 48'd1);
        check_output("t5_frame_count", 48'(frame_count), 48'd0);
        check_output("t5_busy", 48'(busy), 48'd0);
        check_output("t5_overflow", 48'(overflow), 48'd0);
        check_output("t5_ready", 48'(s_if.sample_ready), 48'd1);
        @(negedge clk);
        reset = 1'b0;
        lows  = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_output("t5_line_quiet", 48'(lows), 48'd0);
        check_output("t5_no_more_bytes", 48'(byte_q.size()), 48'd2);
        check_output("t5_busy_after", 48'(busy), 48'd0);
        check_output("framing", 48'(rx_errs), 48'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
